// File: rtl/core_pkg.sv
// Shared definitions for the fetch/decode/execute slice: RV32I opcode and
// funct constants, the decoded-instruction record passed from decode to
// execute, the ALU operation encoding and the immediate-format helpers.
package core_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;   // sub / sra / srai

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    // Load/store funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    // ALU funct3 (register and immediate forms)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    // One flag per RV32I operation plus summary flags; all zero means NOP.
    typedef struct packed {
        logic lui, auipc, jal, jalr;
        logic beq, bne, blt, bge, bltu, bgeu;
        logic lb, lh, lw, lbu, lhu;
        logic sb, sh, sw;
        logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
        logic add, sub, sll, slt, sltu, xor_, srl, sra, or_, and_;
        logic is_load, is_store, uses_reg, writes_to_reg;
    } instr_flags_t;

    typedef struct packed {
        logic [31:0]  pc;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [31:0]  imm;
        instr_flags_t flags;
    } instructions_t;

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] w);
        return {w[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU used by the execute stage.
// Ports: op (operation select), a / b (operands), y (wrap-around result).
// Shift amounts use only b[4:0]; slt is signed, sltu unsigned.
module alu
    import core_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'b0, a < b};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_execute.sv
// Three independent pipeline-stage engines of an RV32I core.
// Fetch   : f_enabled starts a 2-edge ROM read of f_pc (rom_addr/rom_data),
//           result on f_instr_raw/f_pc_n with f_completed.
// Decode  : d_enabled registers the decoded d_instr_raw into d_instr (1 edge);
//           d_rs1/d_rs2 are combinational for a parallel register-file read.
// Execute : e_enabled registers e_result, branch/jump outcome, e_instr_n and
//           e_rs2_val_n (1 edge).
// Registered outputs hold while their enable is low; rst (synchronous,
// active-high) clears every output and returns fetch to IDLE.
module fetch_decode_execute
    import core_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          f_enabled,
    input  logic [31:0]   f_pc,
    output logic [31:0]   rom_addr,
    input  logic [31:0]   rom_data,
    output logic          f_completed,
    output logic [31:0]   f_pc_n,
    output logic [31:0]   f_instr_raw,
    input  logic          d_enabled,
    input  logic [31:0]   d_pc,
    input  logic [31:0]   d_instr_raw,
    output logic          d_completed,
    output instructions_t d_instr,
    output logic [4:0]    d_rs1,
    output logic [4:0]    d_rs2,
    input  logic          e_enabled,
    input  instructions_t e_instr,
    input  logic [31:0]   e_rs1_val,
    input  logic [31:0]   e_rs2_val,
    output logic          e_completed,
    output instructions_t e_instr_n,
    output logic [31:0]   e_rs2_val_n,
    output logic [31:0]   e_result,
    output logic          e_is_jump_chosen,
    output logic [31:0]   e_jump_dest
);

    // ---------------- Fetch ----------------
    typedef enum logic {F_IDLE, F_WAIT} fetch_state_t;

    fetch_state_t f_state, f_state_nx;
    logic [31:0]  rom_addr_nx, f_pc_n_nx, f_instr_raw_nx;
    logic         f_completed_nx;

    always_comb begin
        f_state_nx     = f_state;
        rom_addr_nx    = rom_addr;
        f_pc_n_nx      = f_pc_n;
        f_instr_raw_nx = f_instr_raw;
        f_completed_nx = f_completed;
        case (f_state)
            F_IDLE: if (f_enabled) begin
                rom_addr_nx    = f_pc;
                f_pc_n_nx      = f_pc;
                f_completed_nx = 1'b0;
                f_state_nx     = F_WAIT;
            end
            // ROM word for rom_addr is valid now; f_enabled is ignored here.
            F_WAIT: begin
                f_instr_raw_nx = rom_data;
                f_completed_nx = 1'b1;
                f_state_nx     = F_IDLE;
            end
            default: f_state_nx = F_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_state     <= F_IDLE;
            rom_addr    <= '0;
            f_pc_n      <= '0;
            f_instr_raw <= '0;
            f_completed <= 1'b0;
        end else begin
            f_state     <= f_state_nx;
            rom_addr    <= rom_addr_nx;
            f_pc_n      <= f_pc_n_nx;
            f_instr_raw <= f_instr_raw_nx;
            f_completed <= f_completed_nx;
        end
    end

    // ---------------- Decode ----------------
    logic [6:0]    opc, f7;
    logic [2:0]    f3;
    instructions_t dec;

    assign opc   = d_instr_raw[6:0];
    assign f3    = d_instr_raw[14:12];
    assign f7    = d_instr_raw[31:25];
    assign d_rs1 = d_instr_raw[19:15];
    assign d_rs2 = d_instr_raw[24:20];

    always_comb begin
        dec     = '0;
        dec.pc  = d_pc;
        dec.rd  = d_instr_raw[11:7];
        dec.rs1 = d_rs1;
        dec.rs2 = d_rs2;
        case (opc)
            OPC_LUI:   begin dec.imm = imm_u(d_instr_raw); dec.flags.lui   = 1'b1; end
            OPC_AUIPC: begin dec.imm = imm_u(d_instr_raw); dec.flags.auipc = 1'b1; end
            OPC_JAL:   begin dec.imm = imm_j(d_instr_raw); dec.flags.jal   = 1'b1; end
            OPC_JALR:  begin
                dec.imm        = imm_i(d_instr_raw);
                dec.flags.jalr = (f3 == 3'b000);
            end
            OPC_BRANCH: begin
                dec.imm = imm_b(d_instr_raw);
                case (f3)
                    F3_BEQ:  dec.flags.beq  = 1'b1;
                    F3_BNE:  dec.flags.bne  = 1'b1;
                    F3_BLT:  dec.flags.blt  = 1'b1;
                    F3_BGE:  dec.flags.bge  = 1'b1;
                    F3_BLTU: dec.flags.bltu = 1'b1;
                    F3_BGEU: dec.flags.bgeu = 1'b1;
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                dec.imm = imm_i(d_instr_raw);
                case (f3)
                    F3_B:    dec.flags.lb  = 1'b1;
                    F3_H:    dec.flags.lh  = 1'b1;
                    F3_W:    dec.flags.lw  = 1'b1;
                    F3_BU:   dec.flags.lbu = 1'b1;
                    F3_HU:   dec.flags.lhu = 1'b1;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                dec.imm = imm_s(d_instr_raw);
                case (f3)
                    F3_B:    dec.flags.sb = 1'b1;
                    F3_H:    dec.flags.sh = 1'b1;
                    F3_W:    dec.flags.sw = 1'b1;
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                dec.imm = imm_i(d_instr_raw);
                case (f3)
                    F3_ADD:  dec.flags.addi  = 1'b1;
                    F3_SLT:  dec.flags.slti  = 1'b1;
                    F3_SLTU: dec.flags.sltiu = 1'b1;
                    F3_XOR:  dec.flags.xori  = 1'b1;
                    F3_OR:   dec.flags.ori   = 1'b1;
                    F3_AND:  dec.flags.andi  = 1'b1;
                    F3_SLL:  dec.flags.slli  = (f7 == F7_BASE);
                    F3_SR: begin
                        dec.flags.srli = (f7 == F7_BASE);
                        dec.flags.srai = (f7 == F7_ALT);
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  dec.flags.add  = 1'b1;
                        F3_SLL:  dec.flags.sll  = 1'b1;
                        F3_SLT:  dec.flags.slt  = 1'b1;
                        F3_SLTU: dec.flags.sltu = 1'b1;
                        F3_XOR:  dec.flags.xor_ = 1'b1;
                        F3_SR:   dec.flags.srl  = 1'b1;
                        F3_OR:   dec.flags.or_  = 1'b1;
                        F3_AND:  dec.flags.and_ = 1'b1;
                        default: ;
                    endcase
                end else if (f7 == F7_ALT) begin
                    dec.flags.sub = (f3 == F3_ADD);
                    dec.flags.sra = (f3 == F3_SR);
                end
            end
            default: ;
        endcase
        // Summary flags derive from the op flags, so a NOP leaves them all 0.
        dec.flags.is_load  = dec.flags.lb | dec.flags.lh | dec.flags.lw |
                             dec.flags.lbu | dec.flags.lhu;
        dec.flags.is_store = dec.flags.sb | dec.flags.sh | dec.flags.sw;
        dec.flags.uses_reg = (|dec.flags) &
                             ~(dec.flags.lui | dec.flags.auipc | dec.flags.jal);
        dec.flags.writes_to_reg = (|dec.flags) & (dec.rd != 5'd0) & ~dec.flags.is_store &
                                  ~(dec.flags.beq | dec.flags.bne | dec.flags.blt |
                                    dec.flags.bge | dec.flags.bltu | dec.flags.bgeu);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_instr     <= '0;
            d_completed <= 1'b0;
        end else if (d_enabled) begin
            d_instr     <= dec;
            d_completed <= 1'b1;
        end
    end

    // ---------------- Execute ----------------
    alu_op_t     alu_op;
    logic [31:0] alu_a, alu_b, alu_y;
    logic        imm_form, reg_form, taken, jump;
    logic [31:0] dest;

    assign imm_form = e_instr.flags.addi | e_instr.flags.slti | e_instr.flags.sltiu |
                      e_instr.flags.xori | e_instr.flags.ori  | e_instr.flags.andi  |
                      e_instr.flags.slli | e_instr.flags.srli | e_instr.flags.srai;
    assign reg_form = e_instr.flags.add  | e_instr.flags.sub  | e_instr.flags.sll |
                      e_instr.flags.slt  | e_instr.flags.sltu | e_instr.flags.xor_ |
                      e_instr.flags.srl  | e_instr.flags.sra  | e_instr.flags.or_ |
                      e_instr.flags.and_;

    // Every result goes through the single ALU; operands stay 0 for a NOP
    // so the default ADD yields 0.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = '0;
        alu_b  = '0;
        if (e_instr.flags.lui) begin
            alu_b = e_instr.imm;
        end else if (e_instr.flags.auipc) begin
            alu_a = e_instr.pc;
            alu_b = e_instr.imm;
        end else if (e_instr.flags.jal | e_instr.flags.jalr) begin
            alu_a = e_instr.pc;
            alu_b = 32'd4;
        end else if (e_instr.flags.is_load | e_instr.flags.is_store) begin
            alu_a = e_rs1_val;
            alu_b = e_instr.imm;
        end else if (imm_form | reg_form) begin
            alu_a = e_rs1_val;
            alu_b = imm_form ? e_instr.imm : e_rs2_val;
            if (e_instr.flags.sub)                             alu_op = ALU_SUB;
            else if (e_instr.flags.slli  | e_instr.flags.sll)  alu_op = ALU_SLL;
            else if (e_instr.flags.slti  | e_instr.flags.slt)  alu_op = ALU_SLT;
            else if (e_instr.flags.sltiu | e_instr.flags.sltu) alu_op = ALU_SLTU;
            else if (e_instr.flags.xori  | e_instr.flags.xor_) alu_op = ALU_XOR;
            else if (e_instr.flags.srli  | e_instr.flags.srl)  alu_op = ALU_SRL;
            else if (e_instr.flags.srai  | e_instr.flags.sra)  alu_op = ALU_SRA;
            else if (e_instr.flags.ori   | e_instr.flags.or_)  alu_op = ALU_OR;
            else if (e_instr.flags.andi  | e_instr.flags.and_) alu_op = ALU_AND;
        end
    end

    alu u_alu (.op(alu_op), .a(alu_a), .b(alu_b), .y(alu_y));

    assign taken = (e_instr.flags.beq  & (e_rs1_val == e_rs2_val)) |
                   (e_instr.flags.bne  & (e_rs1_val != e_rs2_val)) |
                   (e_instr.flags.blt  & ($signed(e_rs1_val) <  $signed(e_rs2_val))) |
                   (e_instr.flags.bge  & ($signed(e_rs1_val) >= $signed(e_rs2_val))) |
                   (e_instr.flags.bltu & (e_rs1_val <  e_rs2_val)) |
                   (e_instr.flags.bgeu & (e_rs1_val >= e_rs2_val));
    assign jump  = e_instr.flags.jal | e_instr.flags.jalr | taken;
    assign dest  = e_instr.flags.jalr ? ((e_rs1_val + e_instr.imm) & ~32'd1)
                                      : (e_instr.pc + e_instr.imm);

    always_ff @(posedge clk) begin
        if (rst) begin
            e_completed      <= 1'b0;
            e_instr_n        <= '0;
            e_rs2_val_n      <= '0;
            e_result         <= '0;
            e_is_jump_chosen <= 1'b0;
            e_jump_dest      <= '0;
        end else if (e_enabled) begin
            e_completed      <= 1'b1;
            e_instr_n        <= e_instr;
            e_rs2_val_n      <= e_rs2_val;
            e_result         <= alu_y;
            e_is_jump_chosen <= jump;
            e_jump_dest      <= dest;
        end
    end

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Self-checking bench for fetch_decode_execute: table-driven decode and
// execute vectors (execute through a scoreboard queue) plus hand-written
// fetch and reset sequences.
module tb_fetch_decode_execute;
    import core_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_enabled, d_enabled, e_enabled;
    logic [31:0]   f_pc, rom_addr, rom_data, f_pc_n, f_instr_raw;
    logic          f_completed, d_completed, e_completed, e_is_jump_chosen;
    logic [31:0]   d_pc, d_instr_raw, e_rs1_val, e_rs2_val, e_rs2_val_n, e_result, e_jump_dest;
    logic [4:0]    d_rs1, d_rs2;
    instructions_t d_instr, e_instr, e_instr_n;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h0050_0093;
            32'h20:  return 32'h1234_5678;
            default: return 32'h0;
        endcase
    endfunction
    assign rom_data = rom_word(rom_addr);

    fetch_decode_execute dut (
        .clk(clk), .rst(rst),
        .f_enabled(f_enabled), .f_pc(f_pc), .rom_addr(rom_addr), .rom_data(rom_data),
        .f_completed(f_completed), .f_pc_n(f_pc_n), .f_instr_raw(f_instr_raw),
        .d_enabled(d_enabled), .d_pc(d_pc), .d_instr_raw(d_instr_raw),
        .d_completed(d_completed), .d_instr(d_instr), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .e_enabled(e_enabled), .e_instr(e_instr), .e_rs1_val(e_rs1_val), .e_rs2_val(e_rs2_val),
        .e_completed(e_completed), .e_instr_n(e_instr_n), .e_rs2_val_n(e_rs2_val_n),
        .e_result(e_result), .e_is_jump_chosen(e_is_jump_chosen), .e_jump_dest(e_jump_dest)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- execute vectors ----
    typedef struct {
        string         name;
        instructions_t instr;
        logic [31:0]   rs1, rs2;
        logic          chk_res;
        logic [31:0]   res;
        logic          jump;
        logic          chk_dst;
        logic [31:0]   dst;
    } ex_vec_t;

    ex_vec_t ev[$];
    ex_vec_t sb_q[$];

    function automatic instructions_t mk(input logic [31:0] pc, input logic [31:0] imm);
        instructions_t t;
        t     = '0;
        t.pc  = pc;
        t.imm = imm;
        return t;
    endfunction

    task automatic add_ev(input string name, input instructions_t instr,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic chk_res, input logic [31:0] res,
                          input logic jump, input logic chk_dst, input logic [31:0] dst);
        ex_vec_t v;
        v.name = name; v.instr = instr; v.rs1 = rs1; v.rs2 = rs2;
        v.chk_res = chk_res; v.res = res; v.jump = jump; v.chk_dst = chk_dst; v.dst = dst;
        ev.push_back(v);
    endtask

    // ---- decode vectors ----
    typedef struct {
        string         name;
        logic [31:0]   raw, pc;
        logic [4:0]    rs1, rs2;
        logic          chk_all;
        instructions_t exp;
    } de_vec_t;

    de_vec_t dv[$];

    task automatic add_dv(input string name, input logic [31:0] raw, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic chk_all, input instructions_t exp);
        de_vec_t v;
        v.name = name; v.raw = raw; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.chk_all = chk_all; v.exp = exp;
        dv.push_back(v);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        instructions_t t;
        ex_vec_t       e;
        instr_flags_t  last_flags;

        // ---------------- build decode table ----------------
        t = mk(32'h0, 32'd5); t.rd = 1; t.rs1 = 0; t.rs2 = 5;
        t.flags.addi = 1; t.flags.uses_reg = 1; t.flags.writes_to_reg = 1;
        add_dv("addi x1,x0,5", 32'h0050_0093, 32'h0, 5'd0, 5'd5, 1'b1, t);
        t = mk(32'h40, 32'hFFFF_FFFC); t.rd = 28; t.rs1 = 2; t.rs2 = 5;
        t.flags.sw = 1; t.flags.is_store = 1; t.flags.uses_reg = 1;
        add_dv("sw x5,-4(x2)", 32'hFE51_2E23, 32'h40, 5'd2, 5'd5, 1'b1, t);
        t = mk(32'h100, 32'hFFFF_FFF8); t.rd = 25; t.rs1 = 1; t.rs2 = 2;
        t.flags.beq = 1; t.flags.uses_reg = 1;
        add_dv("beq x1,x2,-8", 32'hFE20_8CE3, 32'h100, 5'd1, 5'd2, 1'b1, t);
        t = mk(32'h8, 32'h1234_5000); t.rd = 3; t.rs1 = 8; t.rs2 = 3;
        t.flags.lui = 1; t.flags.writes_to_reg = 1;
        add_dv("lui x3", 32'h1234_51B7, 32'h8, 5'd8, 5'd3, 1'b1, t);
        t = mk(32'hC, 32'd8); t.rd = 6; t.rs1 = 2; t.rs2 = 8;
        t.flags.lw = 1; t.flags.is_load = 1; t.flags.uses_reg = 1; t.flags.writes_to_reg = 1;
        add_dv("lw x6,8(x2)", 32'h0081_2303, 32'hC, 5'd2, 5'd8, 1'b1, t);
        t = mk(32'h200, 32'd16); t.rd = 1; t.rs1 = 0; t.rs2 = 16;
        t.flags.jal = 1; t.flags.writes_to_reg = 1;
        add_dv("jal x1,16", 32'h0100_00EF, 32'h200, 5'd0, 5'd16, 1'b1, t);
        t = '0; t.flags.add = 1; t.flags.uses_reg = 1;
        add_dv("add x0,x1,x2", 32'h0020_8033, 32'h0, 5'd1, 5'd2, 1'b0, t);
        t = '0; t.flags.srai = 1; t.flags.uses_reg = 1; t.flags.writes_to_reg = 1;
        add_dv("srai x1,x1,3", 32'h4030_D093, 32'h0, 5'd1, 5'd3, 1'b0, t);
        t = '0;
        add_dv("bad funct7", 32'h0220_8033, 32'h0, 5'd1, 5'd2, 1'b0, t);
        add_dv("bad funct3", 32'h0000_2063, 32'h0, 5'd0, 5'd0, 1'b0, t);
        add_dv("bad opcode", 32'hFFFF_FFFF, 32'h0, 5'd31, 5'd31, 1'b0, t);

        // ---------------- build execute table ----------------
        t = mk(32'h100, 32'hFFFF_FFF8); t.flags.beq = 1; t.flags.uses_reg = 1;
        add_ev("beq taken", t, 32'd7, 32'd7, 0, 0, 1, 1, 32'hF8);
        add_ev("beq not taken", t, 32'd7, 32'd8, 0, 0, 0, 0, 0);
        t = mk(32'h20, 32'd4); t.flags.jalr = 1; t.flags.uses_reg = 1;
        add_ev("jalr", t, 32'h1003, 32'h0, 1, 32'h24, 1, 1, 32'h1006);
        t = mk(32'h0, 32'hFFFF_FFFC); t.flags.sw = 1; t.flags.is_store = 1; t.flags.uses_reg = 1;
        add_ev("sw", t, 32'h40, 32'hDEAD_BEEF, 1, 32'h3C, 0, 0, 0);
        t = mk(32'h0, 32'h0); t.flags.add = 1;
        add_ev("add wrap", t, 32'hFFFF_FFFF, 32'd1, 1, 32'h0, 0, 0, 0);
        t = mk(32'h0, 32'h0); t.flags.sra = 1;
        add_ev("sra by 33", t, 32'h8000_0000, 32'd33, 1, 32'hC000_0000, 0, 0, 0);
        t = mk(32'h50, 32'h77);
        add_ev("nop", t, 32'd5, 32'd6, 1, 32'h0, 0, 0, 0);
        t = mk(32'h4, 32'h1234_5000); t.flags.lui = 1;
        add_ev("lui", t, 32'd99, 32'd0, 1, 32'h1234_5000, 0, 0, 0);
        t = mk(32'h1000, 32'h2000); t.flags.auipc = 1;
        add_ev("auipc", t, 32'd0, 32'd0, 1, 32'h3000, 0, 0, 0);
        t = mk(32'h200, 32'h10); t.flags.jal = 1;
        add_ev("jal", t, 32'd0, 32'd0, 1, 32'h204, 1, 1, 32'h210);
        t = mk(32'h0, 32'h0); t.flags.slt = 1;
        add_ev("slt signed", t, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 0, 0, 0);
        t = mk(32'h0, 32'h0); t.flags.sltu = 1;
        add_ev("sltu unsigned", t, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 0, 0, 0);
        t = mk(32'h300, 32'h20); t.flags.blt = 1;
        add_ev("blt taken", t, 32'hFFFF_FFFF, 32'd1, 0, 0, 1, 1, 32'h320);
        t = mk(32'h300, 32'h20); t.flags.bltu = 1;
        add_ev("bltu not taken", t, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 0);
        t = mk(32'h300, 32'hFFFF_FF00); t.flags.bge = 1;
        add_ev("bge taken", t, 32'd1, 32'hFFFF_FFFF, 0, 0, 1, 1, 32'h200);
        t = mk(32'h300, 32'h20); t.flags.bgeu = 1;
        add_ev("bgeu not taken", t, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        t = mk(32'h40, 32'h8); t.flags.bne = 1;
        add_ev("bne taken", t, 32'd3, 32'd4, 0, 0, 1, 1, 32'h48);
        t = mk(32'h0, 32'h0); t.flags.sub = 1;
        add_ev("sub", t, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 0, 0, 0);
        t = mk(32'h0, 32'd4); t.flags.srli = 1;
        add_ev("srli", t, 32'h8000_0000, 32'd0, 1, 32'h0800_0000, 0, 0, 0);
        t = mk(32'h0, 32'h1F); t.flags.slli = 1;
        add_ev("slli 31", t, 32'd1, 32'd0, 1, 32'h8000_0000, 0, 0, 0);
        t = mk(32'h0, 32'hFFFF_FFFF); t.flags.xori = 1;
        add_ev("xori -1", t, 32'hF0F0_F0F0, 32'd0, 1, 32'h0F0F_0F0F, 0, 0, 0);
        t = mk(32'h0, 32'h0); t.flags.or_ = 1;
        add_ev("or", t, 32'hF0, 32'h0F, 1, 32'hFF, 0, 0, 0);
        t = mk(32'h0, 32'h0); t.flags.and_ = 1;
        add_ev("and", t, 32'hFF, 32'h3C, 1, 32'h3C, 0, 0, 0);
        t = mk(32'h0, 32'hFFFF_FFF0); t.flags.lw = 1; t.flags.is_load = 1;
        add_ev("lw addr", t, 32'h1000, 32'd0, 1, 32'hFF0, 0, 0, 0);
        t = mk(32'h0, 32'hFFFF_FFFF); t.flags.sltiu = 1;
        add_ev("sltiu", t, 32'd5, 32'd0, 1, 32'd1, 0, 0, 0);
        t = mk(32'h0, 32'h0); t.flags.srl = 1;
        add_ev("srl by 36", t, 32'h100, 32'd36, 1, 32'h10, 0, 0, 0);

        // ---------------- reset state ----------------
        rst = 1'b1; f_enabled = 0; d_enabled = 0; e_enabled = 0;
        f_pc = '0; d_pc = '0; d_instr_raw = '0; e_instr = '0; e_rs1_val = '0; e_rs2_val = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset rom_addr", rom_addr, 0);
        check("reset f_completed", f_completed, 0);
        check("reset f_instr_raw", f_instr_raw, 0);
        check("reset d_completed", d_completed, 0);
        check("reset d_instr", d_instr, 0);
        check("reset e_completed", e_completed, 0);
        check("reset e_instr_n", e_instr_n, 0);
        check("reset e_result", e_result, 0);

        // ---------------- fetch: basic 2-edge read ----------------
        f_pc = 32'h10; f_enabled = 1;
        tick();
        f_enabled = 0;
        check("fetch edge1 rom_addr", rom_addr, 32'h10);
        check("fetch edge1 f_completed", f_completed, 0);
        tick();
        check("fetch edge2 f_completed", f_completed, 1);
        check("fetch edge2 f_instr_raw", f_instr_raw, 32'h0050_0093);
        check("fetch edge2 f_pc_n", f_pc_n, 32'h10);
        f_pc = 32'h99;
        tick(); tick();
        check("fetch hold f_completed", f_completed, 1);
        check("fetch hold f_instr_raw", f_instr_raw, 32'h0050_0093);
        check("fetch hold rom_addr", rom_addr, 32'h10);

        // ---------------- fetch: enable ignored in WAIT ----------------
        f_pc = 32'h20; f_enabled = 1;
        tick();
        f_pc = 32'h30;
        tick();
        f_enabled = 0;
        check("wait-ignore rom_addr", rom_addr, 32'h20);
        check("wait-ignore f_pc_n", f_pc_n, 32'h20);
        check("wait-ignore f_instr_raw", f_instr_raw, 32'h1234_5678);
        check("wait-ignore f_completed", f_completed, 1);

        // ---------------- fetch: reset during WAIT ----------------
        f_pc = 32'h10; f_enabled = 1;
        tick();
        f_enabled = 0; rst = 1;
        tick();
        rst = 0;
        check("abort f_completed", f_completed, 0);
        check("abort rom_addr", rom_addr, 0);
        check("abort f_instr_raw", f_instr_raw, 0);
        tick();
        check("abort idle f_completed", f_completed, 0);
        f_pc = 32'h20; f_enabled = 1;
        tick();
        f_enabled = 0;
        tick();
        check("after abort f_completed", f_completed, 1);
        check("after abort f_instr_raw", f_instr_raw, 32'h1234_5678);

        // ---------------- decode table ----------------
        foreach (dv[i]) begin
            d_instr_raw = dv[i].raw; d_pc = dv[i].pc; d_enabled = 1;
            #1;
            check({dv[i].name, " d_rs1"}, d_rs1, dv[i].rs1);
            check({dv[i].name, " d_rs2"}, d_rs2, dv[i].rs2);
            tick();
            d_enabled = 0;
            check({dv[i].name, " d_completed"}, d_completed, 1);
            check({dv[i].name, " flags"}, d_instr.flags, dv[i].exp.flags);
            if (dv[i].chk_all)
                check({dv[i].name, " d_instr"}, d_instr, dv[i].exp);
        end
        last_flags = dv[dv.size()-1].exp.flags;
        // Hold: decode enable low, raw word changes.
        d_instr_raw = 32'h0050_0093;
        tick(); tick();
        check("decode hold flags", d_instr.flags, last_flags);
        check("decode hold d_completed", d_completed, 1);

        // ---------------- execute table via scoreboard ----------------
        foreach (ev[i]) begin
            e_instr = ev[i].instr; e_rs1_val = ev[i].rs1; e_rs2_val = ev[i].rs2; e_enabled = 1;
            sb_q.push_back(ev[i]);
            tick();
            e_enabled = 0;
            e = sb_q.pop_front();
            check({e.name, " e_completed"}, e_completed, 1);
            if (e.chk_res) check({e.name, " e_result"}, e_result, e.res);
            check({e.name, " jump"}, e_is_jump_chosen, e.jump);
            if (e.chk_dst) check({e.name, " dest"}, e_jump_dest, e.dst);
            check({e.name, " rs2_n"}, e_rs2_val_n, e.rs2);
            check({e.name, " instr_n"}, e_instr_n, e.instr);
        end
        // Hold: execute enable low, operands change.
        e_rs1_val = 32'h5555_5555; e_rs2_val = 32'h1;
        tick();
        check("exec hold e_result", e_result, e.res);
        check("exec hold rs2_n", e_rs2_val_n, e.rs2);

        // ---------------- unknown opcode through decode and execute ----------------
        d_instr_raw = 32'hFFFF_FFFF; d_pc = 32'h80; d_enabled = 1;
        tick();
        d_enabled = 0;
        e_instr = d_instr; e_rs1_val = 32'd123; e_rs2_val = 32'd123; e_enabled = 1;
        tick();
        e_enabled = 0;
        check("unknown e_result", e_result, 0);
        check("unknown jump", e_is_jump_chosen, 0);

        // ---------------- reset overrides simultaneous enables ----------------
        f_pc = 32'h10; f_enabled = 1; d_enabled = 1; e_enabled = 1; rst = 1;
        d_instr_raw = 32'h0050_0093;
        t = mk(32'h20, 32'd4); t.flags.jalr = 1;
        e_instr = t;
        tick();
        rst = 0; f_enabled = 0; d_enabled = 0; e_enabled = 0;
        check("rst+en rom_addr", rom_addr, 0);
        check("rst+en d_completed", d_completed, 0);
        check("rst+en d_instr", d_instr, 0);
        check("rst+en e_completed", e_completed, 0);
        check("rst+en e_instr_n", e_instr_n, 0);
        check("rst+en e_jump", e_is_jump_chosen, 0);
        tick();
        check("rst+en f_completed", f_completed, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
